// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI slave transaction controller.
package spi_fsm_pkg;

  // Edges per field (7 address bits + R/W bit, then 8 data bits).
  localparam int FIELD_BITS_DEF = 8;

  // R/W bit encoding as it appears in parallelDataOut[0].
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // State encoding, 4-bit binary.
  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_GET_ADDR    = 4'd1;
  localparam logic [3:0] ST_LATCH_ADDR  = 4'd2;
  localparam logic [3:0] ST_READ_WAIT   = 4'd3;
  localparam logic [3:0] ST_READ_LOAD   = 4'd4;
  localparam logic [3:0] ST_READ_SHIFT  = 4'd5;
  localparam logic [3:0] ST_WRITE_SHIFT = 4'd6;
  localparam logic [3:0] ST_WRITE_MEM   = 4'd7;
  localparam logic [3:0] ST_DONE        = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE        = ST_IDLE,
    S_GET_ADDR    = ST_GET_ADDR,
    S_LATCH_ADDR  = ST_LATCH_ADDR,
    S_READ_WAIT   = ST_READ_WAIT,
    S_READ_LOAD   = ST_READ_LOAD,
    S_READ_SHIFT  = ST_READ_SHIFT,
    S_WRITE_SHIFT = ST_WRITE_SHIFT,
    S_WRITE_MEM   = ST_WRITE_MEM,
    S_DONE        = ST_DONE
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// SCLK edge counter shared by the address and data phases.
module spi_bit_counter
  import spi_fsm_pkg::*;
#(
  parameter int FIELD_BITS = FIELD_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = cnt_width(FIELD_BITS);
  localparam logic [W-1:0] LAST = W'(FIELD_BITS - 1);

  logic [W-1:0] count_q;

  // Clear wins over enable so a state change always restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/spi_fsm.sv
// Transaction controller for the SPI memory slave (Moore outputs).
module spi_fsm
  import spi_fsm_pkg::*;
#(
  parameter int FIELD_BITS       = FIELD_BITS_DEF,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_posedge,
  input  logic rw_bit,
  output logic addr_we,
  output logic dm_we,
  output logic sr_we,
  output logic miso_buff_en
);

  localparam int WW = cnt_width(MEM_READ_LATENCY);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_READ_LATENCY - 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          cnt_clr, cnt_en, cnt_tc;

  spi_bit_counter #(
    .FIELD_BITS(FIELD_BITS)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear_i(cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  // State and memory-latency wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; chip-select release aborts from any active state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_en  = 1'b0;
    if (cs_n && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!cs_n) state_d = S_GET_ADDR;
        end
        S_GET_ADDR: begin
          if (sclk_posedge) begin
            if (cnt_tc) state_d = S_LATCH_ADDR;
            else        cnt_en  = 1'b1;
          end
        end
        S_LATCH_ADDR: begin
          // The shift register already holds the 8th bit, so rw_bit is valid now.
          unique case (rw_bit)
            RW_READ:  state_d = (MEM_READ_LATENCY == 0) ? S_READ_LOAD : S_READ_WAIT;
            RW_WRITE: state_d = S_WRITE_SHIFT;
          endcase
        end
        S_READ_WAIT: begin
          if (wait_q == WAIT_LAST) state_d = S_READ_LOAD;
          else                     wait_d  = wait_q + WW'(1);
        end
        S_READ_LOAD: begin
          state_d = S_READ_SHIFT;
        end
        S_READ_SHIFT, S_WRITE_SHIFT: begin
          if (sclk_posedge) begin
            if (cnt_tc) state_d = (state_q == S_READ_SHIFT) ? S_DONE : S_WRITE_MEM;
            else        cnt_en  = 1'b1;
          end
        end
        S_WRITE_MEM: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // Every state change restarts both counters.
    if (state_d != state_q) wait_d = '0;
  end

  assign cnt_clr = (state_d != state_q);

  // Output decode from the registered state only.
  always_comb begin
    addr_we      = 1'b0;
    dm_we        = 1'b0;
    sr_we        = 1'b0;
    miso_buff_en = 1'b0;
    unique case (state_q)
      S_LATCH_ADDR: addr_we      = 1'b1;
      S_READ_LOAD:  sr_we        = 1'b1;
      S_READ_SHIFT: miso_buff_en = 1'b1;
      S_WRITE_MEM:  dm_we        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench: event-count reference model compared every clk cycle.
module tb_spi_fsm;

  localparam int FB  = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset, cs_n, sclk_posedge, rw_bit;
  logic addr_we, dm_we, sr_we, miso_buff_en;

  int checks = 0;
  int errors = 0;

  // Reference model: counts SCLK edges per frame and cycles since field ends.
  bit in_frame = 1'b0;
  bit rw_m     = 1'b0;
  int edges    = 0;   // accepted address-field edges
  int dedges   = 0;   // accepted data-field edges
  int t8       = 0;   // cycles since the last address edge (1 = latch cycle)
  int t16      = 0;   // cycles since the last data edge

  spi_fsm #(
    .FIELD_BITS      (FB),
    .MEM_READ_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .sclk_posedge(sclk_posedge),
    .rw_bit      (rw_bit),
    .addr_we     (addr_we),
    .dm_we       (dm_we),
    .sr_we       (sr_we),
    .miso_buff_en(miso_buff_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clk edge with the inputs sampled at that edge.
  task automatic model_step(input bit r, input bit c, input bit p, input bit rwb);
    bit shift_ok;
    if (r) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (!c) begin
        in_frame = 1'b1;
        rw_m = 1'b0; edges = 0; dedges = 0; t8 = 0; t16 = 0;
      end
    end else if (c) begin
      in_frame = 1'b0;
    end else if (edges < FB) begin
      if (p) begin
        edges++;
        if (edges == FB) t8 = 1;
      end
    end else begin
      // Data edges count only once the shift phase is open.
      shift_ok = rw_m ? (t8 >= 3 + LAT) : (t8 >= 2);
      if (t8 == 1) rw_m = rwb;
      if (dedges < FB) begin
        if (p && shift_ok) begin
          dedges++;
          if (dedges == FB) t16 = 1;
        end
      end else begin
        t16++;
      end
      t8++;
    end
  endtask

  task automatic check_outputs();
    bit e_addr, e_sr, e_miso, e_dm;
    e_addr = in_frame && (t8 == 1);
    e_sr   = in_frame && rw_m && (t8 == 2 + LAT);
    e_miso = in_frame && rw_m && (t8 >= 3 + LAT) && (dedges < FB);
    e_dm   = in_frame && !rw_m && (t16 == 1);
    chk("addr_we", addr_we, e_addr);
    chk("sr_we", sr_we, e_sr);
    chk("miso_buff_en", miso_buff_en, e_miso);
    chk("dm_we", dm_we, e_dm);
    chk("we_exclusive", logic'(($countones({addr_we, dm_we, sr_we}) <= 1)), 1'b1);
  endtask

  task automatic tick(input bit r, input bit c, input bit p, input bit rwb);
    reset = r; cs_n = c; sclk_posedge = p; rw_bit = rwb;
    @(posedge clk);
    model_step(r, c, p, rwb);
    #1;
    check_outputs();
  endtask

  // Idle cycles with chip select high and stray SCLK pulses.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'($urandom), 1'($urandom));
  endtask

  // One frame; abort_at = edge number (1..2*FB) after which cs_n rises, -1 = none.
  task automatic frame(input bit rwv, input int abort_at, input bit coincide);
    int gap;
    $display("frame rw=%0b abort_at=%0d coincide=%0b t=%0t", rwv, abort_at, coincide, $time);
    tick(1'b0, 1'b0, 1'b0, 1'($urandom));
    for (int k = 1; k <= 2 * FB; k++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, 1'($urandom));
      if (k == abort_at && coincide) begin
        tick(1'b0, 1'b1, 1'b1, 1'($urandom));
        return;
      end
      tick(1'b0, 1'b0, 1'b1, 1'($urandom));
      if (k == abort_at) begin
        tick(1'b0, 1'b1, 1'b0, 1'($urandom));
        return;
      end
      if (k == FB) begin
        // Minimum protocol gap; rw_bit is meaningful only on the latch cycle.
        for (int g = 0; g < LAT + 2; g++)
          tick(1'b0, 1'b0, 1'b0, (g == 0) ? rwv : 1'($urandom));
      end
    end
    // DONE guard: pulses with chip select still low.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    tick(1'b0, 1'b1, 1'b0, 1'($urandom));
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b0; sclk_posedge = 1'b0; rw_bit = 1'b0;
    // Reset held with chip select low and SCLK pulsing.
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    // Directed frames.
    frame(1'b0, -1, 1'b0);            // write
    idle(3);
    frame(1'b1, -1, 1'b0);            // read
    frame(1'b0, 4, 1'b0);             // abort after 4th address edge
    frame(1'b0, -1, 1'b0);            // back-to-back restart
    frame(1'b0, 2 * FB, 1'b1);        // cs_n with last data edge
    frame(1'b0, 2 * FB, 1'b0);        // cs_n during write-memory cycle
    frame(1'b1, FB + 4, 1'b0);        // abort mid read data
    frame(1'b1, FB, 1'b1);            // cs_n with last address edge
    // Reset in the middle of a frame.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      frame(1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * FB)) : -1,
            1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
